pipelined_addsub: RTL and testbench

Parametrised, pipelined add/subtract unit; the next generation of the team's 8-bit ripple-carry adder. WIDTH-bit operands are split into STAGES equal carry chunks, with one chunk resolved per pipeline stage, so the clock period stays bounded as WIDTH grows. It sits between operand producers and result consumers as a valid/ready elastic stage, and adds subtract mode, signed-overflow reporting and optional saturation.

---
 rtl/pipelined_addsub.sv | 109 ++++++++++
 tb/tb_pipelined_addsub.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
// Elastic add/subtract pipeline: WIDTH bits in STAGES carry chunks, one chunk per stage.
// Optional signed saturation at the final stage when PIPELINED_ADDSUB_SAT_EN is defined.
module pipelined_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CH = WIDTH / STAGES;

    logic [STAGES-1:0]            v_q, v_in, c_q, c_n;
    logic [STAGES:0]              en;
    logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, s_q, a_n, b_n, s_n;
    logic                         ovf_q, ovf_n;

    // A stage may load when empty or when the stage after it is moving.
    assign en[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        logic [WIDTH-1:0] ai, bi, si, sm;
        logic             ci;
        logic [CH:0]      add;

        assign en[k] = !v_q[k] || en[k+1];

        if (k == 0) begin : g_first
            assign ai      = a;
            assign bi      = sub ? ~b : b;
            assign si      = '0;
            assign ci      = cin;
            assign v_in[k] = in_valid;
        end else begin : g_next
            assign ai      = a_q[k-1];
            assign bi      = b_q[k-1];
            assign si      = s_q[k-1];
            assign ci      = c_q[k-1];
            assign v_in[k] = v_q[k-1];
        end

        assign add = {1'b0, ai[k*CH +: CH]} + {1'b0, bi[k*CH +: CH]} + {{CH{1'b0}}, ci};

        always_comb begin
            sm = si;
            sm[k*CH +: CH] = add[CH-1:0];
        end

        assign a_n[k] = ai;
        assign b_n[k] = bi;
        assign c_n[k] = add[CH];

        if (k == STAGES - 1) begin : g_last
            logic msb_cin;
            // Carry into the MSB recovered from its sum bit and operand bits.
            assign msb_cin = sm[WIDTH-1] ^ ai[WIDTH-1] ^ bi[WIDTH-1];
            assign ovf_n   = msb_cin ^ add[CH];
`ifdef PIPELINED_ADDSUB_SAT_EN
            logic [WIDTH-1:0] sat;
            assign sat    = (!ai[WIDTH-1] && !bi[WIDTH-1]) ? {1'b0, {(WIDTH-1){1'b1}}}
                                                           : {1'b1, {(WIDTH-1){1'b0}}};
            assign s_n[k] = ovf_n ? sat : sm;
`else
            assign s_n[k] = sm;
`endif
        end else begin : g_pass
            assign s_n[k] = sm;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (en[k]) begin
                    v_q[k] <= v_in[k];
                    a_q[k] <= a_n[k];
                    b_q[k] <= b_n[k];
                    s_q[k] <= s_n[k];
                    c_q[k] <= c_n[k];
                end
            end
            if (en[STAGES-1]) ovf_q <= ovf_n;
        end
    end

    assign in_ready  = en[0];
    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed and random checks of pipelined_addsub (16b/4 stages and 8b/1 stage).
module tb_pipelined_addsub;
    localparam int W = 16, S = 4;

    logic clk = 1'b0, rst_n = 1'b0;
    logic in_valid = 1'b0, cin = 1'b0, sub = 1'b0, out_ready = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic in_ready, out_valid, cout, ovf;
    logic [W-1:0] sum;

    logic in_valid1 = 1'b0, cin1 = 1'b0, sub1 = 1'b0, out_ready1 = 1'b0;
    logic [7:0] a1 = '0, b1 = '0;
    logic in_ready1, out_valid1, cout1, ovf1;
    logic [7:0] sum1;

    pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf));

    pipelined_addsub #(.WIDTH(8), .STAGES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .sub(sub1), .out_valid(out_valid1),
        .out_ready(out_ready1), .sum(sum1), .cout(cout1), .ovf(ovf1));

    always #5 clk = ~clk;

    int vecs = 0, errs = 0;
    int n0 = 0, n1 = 0, p0 = 0, p1 = 0, extra0 = 0, extra1 = 0;
    logic [33:0] q0[$], q1[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, cout, sum} of x + (s ? ~y : y) + ci at n bits.
    function automatic logic [33:0] ref_n(input int n, input logic [31:0] x, y,
                                          input logic ci, s);
        logic [63:0] m, yy, r;
        logic [31:0] sm;
        logic        o;
        m  = (64'd1 << n) - 64'd1;
        yy = (s ? ~{32'd0, y} : {32'd0, y}) & m;
        r  = {32'd0, x} + yy + {63'd0, ci};
        sm = r[31:0] & m[31:0];
        o  = (x[n-1] == yy[n-1]) && (sm[n-1] != x[n-1]);
`ifdef PIPELINED_ADDSUB_SAT_EN
        if (o) sm = x[n-1] ? (32'd1 << (n-1)) : ((32'd1 << (n-1)) - 32'd1);
`endif
        return {o, r[n], sm};
    endfunction

    // Called mid-cycle: score deliveries, then record acceptances.
    task automatic mon();
        logic [33:0] e;
        if (out_valid && out_ready) begin
            if (q0.size() == 0) extra0++;
            else begin
                e = q0.pop_front();
                chk("out16", {13'd0, ovf, cout, sum}, {13'd0, e[33], e[32], e[15:0]});
                n0++;
            end
        end
        if (in_valid && in_ready) begin
            q0.push_back(ref_n(16, {16'd0, a}, {16'd0, b}, cin, sub));
            p0++;
        end
        if (out_valid1 && out_ready1) begin
            if (q1.size() == 0) extra1++;
            else begin
                e = q1.pop_front();
                chk("out8", {21'd0, ovf1, cout1, sum1}, {21'd0, e[33], e[32], e[7:0]});
                n1++;
            end
        end
        if (in_valid1 && in_ready1) begin
            q1.push_back(ref_n(8, {24'd0, a1}, {24'd0, b1}, cin1, sub1));
            p1++;
        end
    endtask

    // Single beat into an empty pipeline; checks latency and result.
    task automatic send_one(input string tag, input logic [15:0] xa, xb,
                            input logic xc, xs, input logic [15:0] es,
                            input logic ec, eo);
        int lat;
        a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1; out_ready = 1'b1;
        #1 chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".latency"}, lat, S);
        chk({tag, ".sum"}, {16'd0, sum}, {16'd0, es});
        chk({tag, ".cout"}, {31'd0, cout}, {31'd0, ec});
        chk({tag, ".ovf"}, {31'd0, ovf}, {31'd0, eo});
        @(posedge clk); #1;
    endtask

    initial begin
        int idx, stale;
        logic [15:0] sa;

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.sum", {16'd0, sum}, 32'd0);
        chk("rst.cout_ovf", {30'd0, cout, ovf}, 32'd0);
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst.out_valid8", {31'd0, out_valid1}, 32'd0);

        send_one("add_chunk_carry", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        send_one("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        send_one("carry_all", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        send_one("sub_equal", 16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
`ifdef PIPELINED_ADDSUB_SAT_EN
        send_one("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        send_one("ovf_neg", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1);
`else
        send_one("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        send_one("ovf_neg", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif

        // 10 back-to-back beats, consumer stalls in cycles 3..7.
        idx = 0;
        n0 = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            in_valid = (idx < 10);
            a   = 16'(16'h7F00 + idx * 16'h1357);
            b   = 16'(16'h0F0F ^ (idx * 16'h0421));
            cin = idx[0];
            sub = idx[1];
            out_ready = !(cyc >= 3 && cyc <= 7);
            @(negedge clk);
            if (cyc >= 4 && cyc <= 7) begin
                chk("stall.in_ready", {31'd0, in_ready}, 32'd0);
                chk("stall.out_valid", {31'd0, out_valid}, 32'd1);
                if (q0.size() > 0) chk("stall.sum", {16'd0, sum}, {16'd0, q0[0][15:0]});
            end
            if (in_valid && in_ready) idx++;
            mon();
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("stream.delivered", n0, 10);
        chk("stream.accepted", idx, 10);

        // Reset with three beats held in a stalled pipeline.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = 16'(16'h1000 * (i + 1));
            b = 16'h0011;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst.sum", {16'd0, sum}, 32'd0);
        chk("midrst.cout_ovf", {30'd0, cout, ovf}, 32'd0);
        chk("midrst.in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("midrst.stale", stale, 0);
        @(posedge clk); #1;
        send_one("post_rst", 16'h4321, 16'h1111, 1'b1, 1'b0, 16'h5433, 1'b0, 1'b0);

        // Random traffic on both configurations.
        n0 = 0; p0 = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            in_valid   = ($urandom_range(3) != 0);
            out_ready  = ($urandom_range(3) != 0);
            in_valid1  = ($urandom_range(3) != 0);
            out_ready1 = ($urandom_range(3) != 0);
            sa = 16'($urandom);
            a  = sa;
            b  = 16'($urandom);
            cin = 1'($urandom);
            sub = 1'($urandom);
            a1  = 8'($urandom);
            b1  = 8'($urandom);
            cin1 = 1'($urandom);
            sub1 = 1'($urandom);
            @(negedge clk);
            mon();
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_valid1 = 1'b0; out_ready = 1'b1; out_ready1 = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            mon();
            @(posedge clk); #1;
        end
        chk("rnd16.count", n0, p0);
        chk("rnd8.count", n1, p1);
        chk("rnd16.left", q0.size(), 0);
        chk("rnd8.left", q1.size(), 0);
        chk("extra16", extra0, 0);
        chk("extra8", extra1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
